branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences the 2-bit branch history table between Fetch and EX.
- Records each fetched branch's predicted direction in an in-flight FIFO and checks it against the actual outcome when the branch resolves in EX.
- Drives the registered update strobe, address and outcome into the history table.
- On a mispredict, issues a one-shot PC redirect and holds a pipeline flush for FLUSH_CYCLES.

Parameters:
- ADDR_W, 5: history-table index width; index = PC+4 bits [ADDR_W-1:0].
- PC_W, 32: PC width.
- DEPTH, 4: in-flight prediction FIFO entries; power of 2, ≥2.
- FLUSH_CYCLES, 2: cycles Flush is held after a mispredict; ≥1.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Fetch_Branch  in  1  fetched instruction is a conditional branch (predecode); push request.
- Pred_Taken  in  1  history-table prediction for the current fetch.
- Branch_EX  in  1  branch resolving in EX this cycle; pop request.
- Outcome  in  1  actual direction (1 = taken).
- PC4_EX  in  PC_W  PC+4 of the EX branch.
- Target_EX  in  PC_W  computed branch target.
- Update_En  out  1  history-table update strobe.
- Update_Addr  out  ADDR_W  history-table index to update.
- Update_Outcome  out  1  direction to train.
- Redirect_Valid  out  1  one-cycle PC redirect.
- Redirect_PC  out  PC_W  corrected fetch PC.
- Flush  out  1  squash IF/ID/EX younger instructions.
- Fetch_Stall  out  1  FIFO full; Fetch must hold.
- Underflow_Err  out  1  sticky: EX branch arrived with FIFO empty.
- Resolved_Cnt  out  16  resolved branches (see optional feature).
- Mispred_Cnt  out  16  mispredicts (see optional feature).

Behaviour:
- Reset:
  - FSM = RUN; FIFO emptied (head = tail = count = 0).
  - All outputs 0; counters 0; Underflow_Err cleared.
  - Reset mid-flush aborts the flush immediately.
- FIFO:
  - 1-bit entries holding the predicted direction.
  - count is 0..DEPTH; pointers wrap modulo DEPTH.
  - Fetch_Stall = (count == DEPTH), combinational.
- Push, in RUN only:
  - Occurs if Fetch_Branch && (count < DEPTH || pop this cycle).
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - A push when full with no pop is dropped.
- Pop / resolve, in RUN with Branch_EX = 1:
  - pred = head entry, or 0 (not-taken) if empty; an empty-FIFO resolve also sets Underflow_Err (sticky until Reset).
  - Next cycle: Update_En = 1, Update_Addr = PC4_EX[ADDR_W-1:0], Update_Outcome = Outcome.
  - Update latency is 1 cycle; the history table samples on negedge of that cycle.
- Mispredict (pred != Outcome):
  - Next cycle: Redirect_Valid = 1 for exactly one cycle.
  - Redirect_PC = Outcome ? Target_EX : PC4_EX, captured at resolve.
  - FIFO cleared; any same-cycle push is discarded (flush wins).
  - FSM → FLUSH with counter = FLUSH_CYCLES-1; Flush = 1 from the next cycle.
- FLUSH state:
  - Flush held high; Fetch_Branch and Branch_EX are ignored (no push, no pop, no update).
  - Counter decrements each cycle; at 0 → RUN, and Flush deasserts the following cycle.
  - Flush is high for exactly FLUSH_CYCLES cycles.
- Outside the events above: Update_En = 0, Redirect_Valid = 0.
- Redirect_PC holds its last value.
- Back-to-back resolves in RUN produce back-to-back Update_En pulses.

Optional Feature:
- BRCTRL_STATS_EN defined:
  - Resolved_Cnt increments on every accepted resolve.
  - Mispred_Cnt increments on every mispredict.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on Reset.
- BRCTRL_STATS_EN undefined: both outputs tied to 0; no counter flops.

Test Plan:
- Reset, then push Pred_Taken=1 ×4 (DEPTH=4) → Fetch_Stall=1; a 5th push without pop is dropped; push+pop in the same cycle keeps count=4.
- Correct prediction: push pred=0; resolve Branch_EX=1, Outcome=0, PC4_EX=0x0000_0044 → next cycle Update_En=1, Update_Addr=5'h04, Update_Outcome=0; Redirect_Valid=0, Flush=0.
- Mispredict: push pred=0; resolve Outcome=1, Target_EX=0x0000_0100 → next cycle Redirect_Valid=1 (one cycle), Redirect_PC=0x100; Flush=1 for 2 cycles; FIFO count=0; a Fetch_Branch during flush is ignored.
- Not-taken mispredict with a simultaneous push: pred=1, Outcome=0, PC4_EX=0x0000_0020 → Redirect_PC=0x20; the same-cycle push is discarded; count=0 afterward.
- Branch_EX with empty FIFO and Outcome=1 → treated as pred=0, so a mispredict redirect fires; Underflow_Err=1 and stays set until Reset; asserting Reset mid-flush → Flush=0 the next cycle.
- With BRCTRL_STATS_EN: 3 resolves including 1 mispredict → Resolved_Cnt=3, Mispred_Cnt=1; without the macro both read 0.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: tracks in-flight predictions, trains the history table, redirects and flushes on mispredict.
// Optional build macro BRCTRL_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_ctrl #(
    parameter int ADDR_W       = 5,
    parameter int PC_W         = 32,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Fetch_Branch,
    input  logic              Pred_Taken,
    input  logic              Branch_EX,
    input  logic              Outcome,
    input  logic [PC_W-1:0]   PC4_EX,
    input  logic [PC_W-1:0]   Target_EX,
    output logic              Update_En,
    output logic [ADDR_W-1:0] Update_Addr,
    output logic              Update_Outcome,
    output logic              Redirect_Valid,
    output logic [PC_W-1:0]   Redirect_PC,
    output logic              Flush,
    output logic              Fetch_Stall,
    output logic              Underflow_Err,
    output logic [15:0]       Resolved_Cnt,
    output logic [15:0]       Mispred_Cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state;
    logic [FC_W-1:0]  flush_cnt;
    logic             fifo_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic in_run;
    logic fifo_empty;
    logic pred;
    logic do_pop;
    logic head_adv;
    logic mispred;
    logic do_push;

    // A mispredict squashes everything younger, so it also vetoes the same-cycle push.
    always_comb begin
        in_run     = (state == ST_RUN);
        fifo_empty = (count == '0);
        pred       = fifo_empty ? 1'b0 : fifo_mem[head];
        do_pop     = in_run && Branch_EX;
        head_adv   = do_pop && !fifo_empty;
        mispred    = do_pop && (pred != Outcome);
        do_push    = in_run && Fetch_Branch && !mispred
                     && ((count != CNT_W'(DEPTH)) || do_pop);
    end

    assign Fetch_Stall = (count == CNT_W'(DEPTH));
    assign Flush       = (state == ST_FLUSH);

    always_ff @(posedge Clk) begin
        if (do_push)
            fifo_mem[tail] <= Pred_Taken;
    end

    always_ff @(posedge Clk) begin
        if (Reset || mispred) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                tail <= tail + PTR_W'(1);
            if (head_adv)
                head <= head + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(head_adv);
        end
    end

    // FLUSH lasts FLUSH_CYCLES cycles: entered with FLUSH_CYCLES-1, leaves after counting down to zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mispred) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
                    end
                end
                default: begin
                    if (flush_cnt == '0)
                        state <= ST_RUN;
                    else
                        flush_cnt <= flush_cnt - FC_W'(1);
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Update_En      <= 1'b0;
            Update_Addr    <= '0;
            Update_Outcome <= 1'b0;
            Redirect_Valid <= 1'b0;
            Redirect_PC    <= '0;
            Underflow_Err  <= 1'b0;
        end else begin
            Update_En      <= do_pop;
            Redirect_Valid <= mispred;
            if (do_pop) begin
                Update_Addr    <= PC4_EX[ADDR_W-1:0];
                Update_Outcome <= Outcome;
            end
            if (mispred)
                Redirect_PC <= Outcome ? Target_EX : PC4_EX;
            if (do_pop && fifo_empty)
                Underflow_Err <= 1'b1;
        end
    end

`ifdef BRCTRL_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Resolved_Cnt <= '0;
            Mispred_Cnt  <= '0;
        end else begin
            if (do_pop && (Resolved_Cnt != 16'hFFFF))
                Resolved_Cnt <= Resolved_Cnt + 16'd1;
            if (mispred && (Mispred_Cnt != 16'hFFFF))
                Mispred_Cnt <= Mispred_Cnt + 16'd1;
        end
    end
`else
    assign Resolved_Cnt = '0;
    assign Mispred_Cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Testbench for branch_resolve_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_branch_resolve_ctrl;

    localparam int ADDR_W       = 5;
    localparam int PC_W         = 32;
    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Fetch_Branch;
    logic              Pred_Taken;
    logic              Branch_EX;
    logic              Outcome;
    logic [PC_W-1:0]   PC4_EX;
    logic [PC_W-1:0]   Target_EX;
    logic              Update_En;
    logic [ADDR_W-1:0] Update_Addr;
    logic              Update_Outcome;
    logic              Redirect_Valid;
    logic [PC_W-1:0]   Redirect_PC;
    logic              Flush;
    logic              Fetch_Stall;
    logic              Underflow_Err;
    logic [15:0]       Resolved_Cnt;
    logic [15:0]       Mispred_Cnt;

    always #5 Clk = ~Clk;

    branch_resolve_ctrl #(
        .ADDR_W(ADDR_W), .PC_W(PC_W), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .Fetch_Branch(Fetch_Branch), .Pred_Taken(Pred_Taken),
        .Branch_EX(Branch_EX), .Outcome(Outcome),
        .PC4_EX(PC4_EX), .Target_EX(Target_EX),
        .Update_En(Update_En), .Update_Addr(Update_Addr), .Update_Outcome(Update_Outcome),
        .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC),
        .Flush(Flush), .Fetch_Stall(Fetch_Stall), .Underflow_Err(Underflow_Err),
        .Resolved_Cnt(Resolved_Cnt), .Mispred_Cnt(Mispred_Cnt)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: in-flight predictions as a queue, flush as a count of remaining high cycles.
    bit          predQueue[$];
    int          flushLeft  = 0;
    bit          mUpdEn     = 0;
    int unsigned mUpdAddr   = 0;
    bit          mUpdOut    = 0;
    bit          mRedirValid = 0;
    int unsigned mRedirPc   = 0;
    bit          mUnderflow = 0;
    int          mResolved  = 0;
    int          mMispred   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelStep();
        bit pred;
        bit room;
        mUpdEn      = 0;
        mRedirValid = 0;
        if (Reset) begin
            predQueue.delete();
            flushLeft  = 0;
            mUpdAddr   = 0;
            mUpdOut    = 0;
            mRedirPc   = 0;
            mUnderflow = 0;
            mResolved  = 0;
            mMispred   = 0;
        end else if (flushLeft > 0) begin
            flushLeft--;
        end else begin
            room = (predQueue.size() < DEPTH);
            if (Branch_EX) begin
                if (predQueue.size() == 0) begin
                    pred       = 0;
                    mUnderflow = 1;
                end else begin
                    pred = predQueue.pop_front();
                end
                mUpdEn   = 1;
                mUpdAddr = PC4_EX % (1 << ADDR_W);
                mUpdOut  = Outcome;
                if (mResolved < 65535) mResolved++;
                if (pred != Outcome) begin
                    mRedirValid = 1;
                    mRedirPc    = Outcome ? Target_EX : PC4_EX;
                    predQueue.delete();
                    flushLeft = FLUSH_CYCLES;
                    if (mMispred < 65535) mMispred++;
                end else if (Fetch_Branch) begin
                    predQueue.push_back(Pred_Taken);
                end
            end else if (Fetch_Branch && room) begin
                predQueue.push_back(Pred_Taken);
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit fb, input bit pt, input bit bx,
                                 input bit oc, input logic [31:0] pc4, input logic [31:0] tgt);
        Reset        = rst;
        Fetch_Branch = fb;
        Pred_Taken   = pt;
        Branch_EX    = bx;
        Outcome      = oc;
        PC4_EX       = pc4;
        Target_EX    = tgt;
        @(posedge Clk);
        modelStep();
        #1;
        checkOutput("update_en", 32'(Update_En), 32'(mUpdEn));
        if (mUpdEn) begin
            checkOutput("update_addr", 32'(Update_Addr), mUpdAddr);
            checkOutput("update_outcome", 32'(Update_Outcome), 32'(mUpdOut));
        end
        checkOutput("redirect_valid", 32'(Redirect_Valid), 32'(mRedirValid));
        checkOutput("redirect_pc", Redirect_PC, mRedirPc);
        checkOutput("flush", 32'(Flush), 32'(flushLeft > 0));
        checkOutput("fetch_stall", 32'(Fetch_Stall), 32'(predQueue.size() == DEPTH));
        checkOutput("underflow_err", 32'(Underflow_Err), 32'(mUnderflow));
`ifdef BRCTRL_STATS_EN
        checkOutput("resolved_cnt", 32'(Resolved_Cnt), 32'(mResolved));
        checkOutput("mispred_cnt", 32'(Mispred_Cnt), 32'(mMispred));
`else
        checkOutput("resolved_cnt", 32'(Resolved_Cnt), 32'd0);
        checkOutput("mispred_cnt", 32'(Mispred_Cnt), 32'd0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        // Full FIFO, dropped push, then push+pop while full.
        applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 1, 1, 1, 32'h0000_0008, 32'h0000_0200);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 0, 0, 1, 1, 32'h0000_0010 + 32'(i * 4), 32'h0000_0300);

        // Correct not-taken prediction trains the table without redirect.
        applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 1, 0, 32'h0000_0044, 32'h0000_0080);
        idle(2);

        // Taken mispredict with a fetch attempted during the flush.
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_0048, 32'h0000_0100);
        applyStimulus(0, 1, 1, 1, 0, 32'h0000_0050, 32'h0000_0060);
        applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
        idle(2);

        // Not-taken mispredict with a same-cycle push that must be squashed.
        applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 0, 1, 0, 32'h0000_0020, 32'h0000_0400);
        idle(3);

        // Empty-FIFO resolve, sticky underflow, then reset in the middle of a flush.
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_0030, 32'h0000_0500);
        idle(4);
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_0034, 32'h0000_0600);
        applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(1);

        // Three resolves with one mispredict for the statistics counters.
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 1, 0, 32'h0000_0070, 32'h0000_0700);
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_0074, 32'h0000_0704);
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_0078, 32'h0000_0708);
        idle(3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) < 4,
                          $urandom_range(0, 1) == 1,
                          $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
